// File: rtl/notes_recorder.sv
// Square-wave half-period detector that records the detected note divisor into an
// external note memory once per note slot while rec is held.
module notes_recorder #(
  parameter int unsigned DUR = 2400000,
  parameter int unsigned AW  = 6,
  parameter int unsigned DW  = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ch_in,
  input  logic          rec,
  output logic [DW-1:0] note,
  output logic          note_vld,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          done
);

  localparam int unsigned   TW      = $clog2(DUR);
  localparam logic [DW-1:0] CntMax  = {DW{1'b1}};
  localparam logic [DW-1:0] CntOne  = DW'(1);
  localparam logic [TW-1:0] TimLast = TW'(DUR - 1);
  localparam logic [TW-1:0] TimOne  = TW'(1);
  localparam logic [AW-1:0] AddrLast = {AW{1'b1}};
  localparam logic [AW-1:0] AddrOne  = AW'(1);

  typedef enum logic [1:0] {StIdle, StRec, StDone} state_e;

  logic          r_s1, r_s2, r_s3;
  logic [DW-1:0] r_cnt, r_meas, r_note;
  logic          r_meas_vld, r_armed, r_note_vld;
  logic [TW-1:0] r_timer;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  state_e        r_state, w_state_d;

  logic w_edge, w_accept, w_sat, w_tick, w_run, w_wr, w_done;

  assign w_edge   = r_s2 ^ r_s3;
  assign w_accept = w_edge && r_armed && r_meas_vld && (r_cnt == r_meas);
  // Fire as cnt steps onto MAX so silence lands exactly 2^DW-1 cycles after the last edge.
  assign w_sat    = !w_edge && (r_cnt == (CntMax - CntOne));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= ch_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_meas     <= '0;
      r_meas_vld <= 1'b0;
      r_armed    <= 1'b0;
      r_note     <= '0;
      r_note_vld <= 1'b0;
    end else begin
      r_note_vld <= 1'b0;
      if (w_edge) begin
        r_cnt <= CntOne;
        if (r_armed) begin
          r_meas     <= r_cnt;
          r_meas_vld <= 1'b1;
          if (w_accept && (r_cnt != r_note)) begin
            r_note     <= r_cnt;
            r_note_vld <= 1'b1;
          end
        end else begin
          r_armed <= 1'b1;
        end
      end else begin
        if (r_cnt != CntMax) begin
          r_cnt <= r_cnt + CntOne;
        end
        if (w_sat) begin
          r_note     <= '0;
          r_armed    <= 1'b0;
          r_meas     <= '0;
          r_meas_vld <= 1'b0;
          r_note_vld <= (r_note != '0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (rec) w_state_d = StRec;
      StRec: begin
        if (!rec) begin
          w_state_d = StIdle;
        end else if (r_wr_en && (r_wr_addr == AddrLast)) begin
          w_state_d = StDone;
        end
      end
      StDone: if (!rec) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_run  = (r_state == StRec);
    w_done = (r_state == StDone);
    w_tick = w_run && (r_timer == TimLast);
    // A tick coinciding with rec falling is dropped.
    w_wr   = w_tick && rec;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_timer   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (!w_run || w_tick) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TimOne;
      end
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_data <= r_note;
      end
      if (w_state_d == StIdle) begin
        r_wr_addr <= '0;
      end else if (r_wr_en && (r_wr_addr != AddrLast)) begin
        r_wr_addr <= r_wr_addr + AddrOne;
      end
    end
  end

  assign note     = r_note;
  assign note_vld = r_note_vld;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign done     = w_done;

endmodule

// File: tb/tb_notes_recorder.sv
// Directed bench for notes_recorder: tone acquisition, tone change, silence,
// slot recording, rec abort and asynchronous reset.
module tb_notes_recorder;

  localparam int unsigned DUR = 100;
  localparam int unsigned AW  = 2;
  localparam int unsigned DW  = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ch_in = 1'b0;
  logic          rec = 1'b0;
  logic [DW-1:0] note;
  logic          note_vld;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          done;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  int  cyc = 0;
  int  half = 0;
  int  tog_cnt = 0;
  int  last_tog = 0;
  int  vld_cnt = 0;
  int  n_vec = 0;
  int  n_err = 0;
  wr_t wq[$];

  notes_recorder #(
    .DUR(DUR),
    .AW (AW),
    .DW (DW)
  ) u_dut (
    .clk     (clk),
    .rstn    (rstn),
    .ch_in   (ch_in),
    .rec     (rec),
    .note    (note),
    .note_vld(note_vld),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (note_vld) vld_cnt <= vld_cnt + 1;
    if (wr_en) wq.push_back('{cyc, int'(wr_addr), int'(wr_data)});
  end

  // Tone source: toggles ch_in every `half` cycles, shortly after a rising edge.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #2;
      if (half == 0) begin
        k = 0;
      end else begin
        k++;
        if (k >= half) begin
          ch_in = ~ch_in;
          k = 0;
          tog_cnt++;
          last_tog = cyc;
        end
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_toggles(input int n, input string tag);
    int t0;
    int k;
    t0 = tog_cnt;
    k = 0;
    while ((tog_cnt < t0 + n) && (k < 1000)) begin
      @(negedge clk);
      k++;
    end
    check(tag, int'(tog_cnt >= t0 + n), 1);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int v0;
    int e;

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_note", note, 0);
    check("rst_vld", note_vld, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_done", done, 0);
    rstn = 1'b1;

    // Acquire a half-period of 20.
    half = 20;
    repeat (110) @(negedge clk);
    check("t20_note", note, 20);
    check("t20_vld", vld_cnt, 1);
    repeat (200) @(negedge clk);
    check("t20_stable", vld_cnt, 1);

    // Change to 35: needs two matching half-periods.
    half = 35;
    v0 = vld_cnt;
    wait_toggles(1, "t35_tog1");
    repeat (10) @(negedge clk);
    check("t35_hold", note, 20);
    wait_toggles(1, "t35_tog2");
    repeat (10) @(negedge clk);
    check("t35_note", note, 35);
    check("t35_vld", vld_cnt - v0, 1);

    // Silence: note clears 255 cycles after the last detected edge.
    wait_toggles(1, "sil_tog");
    half = 0;
    v0 = vld_cnt;
    wait_until(last_tog + 256);
    check("sil_before", note, 35);
    @(negedge clk);
    check("sil_note", note, 0);
    check("sil_pulse", note_vld, 1);
    repeat (5) @(negedge clk);
    check("sil_vld", vld_cnt - v0, 1);

    // Re-acquisition needs three edges.
    half = 20;
    wait_toggles(2, "reacq_tog2");
    repeat (10) @(negedge clk);
    check("reacq_two", note, 0);
    wait_toggles(1, "reacq_tog3");
    repeat (10) @(negedge clk);
    check("reacq_three", note, 20);

    // Full recording of four slots.
    wq.delete();
    rec = 1'b1;
    e = cyc + 1;
    wait_until(e + 450);
    check("rec_nwr", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      check($sformatf("rec_cyc%0d", i), wq[i].cyc - e, 100 * (i + 1));
      check($sformatf("rec_addr%0d", i), wq[i].addr, i);
      check($sformatf("rec_data%0d", i), wq[i].data, 20);
    end
    check("rec_done", done, 1);
    rec = 1'b0;
    repeat (2) @(negedge clk);
    check("rec_done_clr", done, 0);
    check("rec_addr_clr", wr_addr, 0);

    // Abort at cycle 150: only slot 0 written.
    wq.delete();
    rec = 1'b1;
    e = cyc + 1;
    wait_until(e + 150);
    rec = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_nwr", wq.size(), 1);
    if (wq.size() > 0) check("abort_addr", wq[0].addr, 0);
    check("abort_wr_addr", wr_addr, 0);

    // Restart begins again at slot 0.
    wq.delete();
    rec = 1'b1;
    e = cyc + 1;
    wait_until(e + 150);
    check("restart_nwr", wq.size(), 1);
    if (wq.size() > 0) begin
      check("restart_cyc", wq[0].cyc - e, 100);
      check("restart_addr", wq[0].addr, 0);
    end
    check("restart_wr_addr", wr_addr, 1);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3;
    rstn = 1'b0;
    rec = 1'b0;
    #1;
    check("arst_note", note, 0);
    check("arst_wr_data", wr_data, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_done", done, 0);
    check("arst_wr_en", wr_en, 0);
    check("arst_vld", note_vld, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wq.delete();
    repeat (120) @(negedge clk);
    check("arst_reacq", note, 20);
    check("arst_nwr", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/notes_recorder.md
Name: notes_recorder

Overview:
Tone detector and recorder for the sequential-sound block family. It measures the half-period of an incoming square wave, in `clk` cycles, and recovers the same note divisor that the note generator consumes: the generator toggles every `note` cycles, so a half-period of N cycles gives note = N. At every note-duration tick it writes the current note into an external 2^AW x DW note memory. The stored table can then be played back by the ROM note player.

Parameters:
- DUR, 2400000, cycles per note slot (200 ms at 12 MHz); minimum 2.
- AW, 6, note-memory address width; a recording holds 2^AW slots.
- DW, 16, note/divisor width; also sets the silence timeout of 2^DW-1 cycles.

Ports:
- clk  input  1  system clock (12 MHz).
- rstn  input  1  asynchronous active-low reset.
- ch_in  input  1  square-wave input, asynchronous to clk.
- rec  input  1  record enable, level-sensitive.
- note  output  DW  current detected note divisor; 0 means silence.
- note_vld  output  1  one-cycle pulse when `note` changes value.
- wr_en  output  1  one-cycle write strobe to the note memory.
- wr_addr  output  AW  write address.
- wr_data  output  DW  write data.
- done  output  1  high once all 2^AW slots are written.

Behaviour:
- Reset:
  - Asynchronous, active-low. Clock is `clk`, reset is `rstn`.
  - While rstn=0, all outputs and all internal registers are 0. This includes the synchronizer, counters, `armed` and the FSM, which resets to IDLE.
- Input path:
  - Two-flop synchronizer on ch_in, plus a third flop for edge detect.
  - edge = s2 XOR s3; both polarities count.
  - Latency from ch_in to edge is a fixed 3 cycles, so it does not affect measured periods.
- Half-period counter cnt, DW bits, saturating at MAX = 2^DW-1:
  - On an edge cycle: meas <= cnt, cnt <= 1.
  - Otherwise: cnt <= cnt+1 unless cnt == MAX.
  - Edges N cycles apart give meas = N. Minimum N = 1 (ch_in toggling every cycle).
- Qualification:
  - The first edge after reset or after silence only sets `armed`; no measurement is taken from it.
  - A measurement is accepted only when it equals the previous accepted-candidate `meas`, i.e. two consecutive identical half-periods.
  - On acceptance, if the value differs from `note`: note <= value and note_vld pulses on the following cycle.
- Silence:
  - When cnt reaches MAX: note <= 0, armed <= 0, candidate cleared, and note_vld pulses if note was non-zero.
  - If an edge and saturation occur in the same cycle, the edge wins.
- Slot timer: count 0..DUR-1; tick is asserted in the cycle where count == DUR-1. The timer runs only in state REC.
- FSM:
  - IDLE: timer and wr_addr held at 0, done=0.
    - rec=1 -> REC. The first tick occurs DUR cycles after entering REC.
  - REC:
    - On tick: wr_en=1 for that cycle, wr_data = note as registered at that cycle (pre-update if note changes in the same cycle), wr_addr = current slot.
    - The cycle after a tick: wr_addr increments.
    - After the write to slot 2^AW-1: -> DONE. No wrap and no overwrite.
    - rec=0 -> IDLE, with wr_addr cleared. If rec falls in a tick cycle, no write occurs.
  - DONE: done=1, no writes.
    - rec=0 -> IDLE, done cleared.
- wr_en, wr_addr and wr_data are registered outputs. wr_data holds its last written value between strobes.
- Detection runs continuously in all FSM states.
- Reset asserted mid-recording aborts the recording immediately. Slots already written are not rolled back.

Test Plan (sim parameters DUR=100, AW=2, DW=8):
- Reset, then ch_in toggling every 20 cycles -> note_vld pulses once, note=20 by roughly the third edge plus 4 cycles; no further pulses while the period is stable.
- Tone changes from half-period 20 to 35 -> note holds 20 through the first 35-cycle half-period, changes to 35 after the second, with exactly one note_vld.
- Stop toggling -> exactly 255 cycles after the last edge note=0 and note_vld pulses. The next tone needs three edges to report.
- rec=1 with note=20 steady -> wr_en at cycles 100/200/300/400 after entering REC, wr_addr 0..3, wr_data=20. done=1 after the 4th write; no 5th write; rec=0 clears done.
- rec dropped at cycle 150 of recording -> one write at slot 0 only, wr_addr returns to 0. Re-asserting rec restarts at slot 0 after 100 cycles.
- Async rstn pulse between clk edges while in REC with note=20 -> all outputs 0 immediately without waiting for clk, FSM in IDLE, and the tone is re-acquired after release.
